alu_seq: RTL and testbench

Sequential, width-parametrised successor to the combinational ALU, with a valid/ready handshake on both sides and registered results. It adds an iterative shift-add multiplier that returns both product halves, a full flag set (zero/negative/carry/overflow), and defined behaviour for every opcode. It sits between the operand/decode stage and write-back, and stalls the upstream stage while a multiply is in progress.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/seq_multiplier.sv | 50 +++++
 rtl/alu_seq.sv | 146 ++++++++++++++
 tb/tb_alu_seq.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and flag bundle for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1110;
  localparam logic [3:0] OP_MULH = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic zf;
    logic nf;
    logic cf;
    logic of;
  } flags_t;

  function automatic logic is_mul(input logic [3:0] aluc);
    return (aluc == OP_MUL) || (aluc == OP_MULH);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, WIDTH cycles per product.
// product is the accumulator after the current step; it holds the final result while done is high.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;

  // Upper half accumulates the multiplicand; the lower half holds the
  // remaining multiplier bits and fills with product bits as it shifts.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    product = {sum, acc[WIDTH-1:1]};
  end

  assign done = busy && (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start && !busy) begin
      busy  <= 1'b1;
      mcand <= multiplicand;
      acc   <= {{WIDTH{1'b0}}, multiplier};
      cnt   <= CW'(WIDTH);
    end else if (busy) begin
      acc <= product;
      cnt <= cnt - CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides; 1-cycle latency for logic/arith, WIDTH cycles for MUL/MULH.
// Results are held in DONE until out_ready; in_ready is high only in IDLE, so upstream stalls during work.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zf,
  output logic             nf,
  output logic             cf,
  output logic             of
);

  state_t             state;
  flags_t             flags_q;
  logic               op_mulh;

  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_d;
  logic [WIDTH-1:0]   alu_r;
  flags_t             alu_f;
  logic [WIDTH-1:0]   mul_r;
  flags_t             mul_f;

  assign mul_start = (state == IDLE) && in_valid && is_mul(aluc) && !mul_busy;

  seq_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk         (clk),
    .rst         (rst),
    .start       (mul_start),
    .multiplicand(a),
    .multiplier  (b),
    .busy        (mul_busy),
    .done        (mul_done),
    .product     (mul_product)
  );

  // Single-cycle datapath works straight off the inputs; its result is
  // registered on the accept edge, which is where operands are captured.
  always_comb begin
    add_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sub_d = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    alu_r = '0;
    alu_f = '0;
    case (aluc)
      OP_AND:  alu_r = a & b;
      OP_OR:   alu_r = a | b;
      OP_NOR:  alu_r = ~(a | b);
      OP_NAND: alu_r = ~(a & b);
      OP_ADD: begin
        alu_r    = add_s[WIDTH-1:0];
        alu_f.cf = add_s[WIDTH];
        alu_f.of = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r    = sub_d[WIDTH-1:0];
        alu_f.cf = sub_d[WIDTH];
        alu_f.of = (a[WIDTH-1] != b[WIDTH-1]) && (sub_d[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_r = '0;
    endcase
    alu_f.zf = (alu_r == '0);
    alu_f.nf = alu_r[WIDTH-1];
  end

  always_comb begin
    mul_f    = '0;
    mul_r    = op_mulh ? mul_product[2*WIDTH-1:WIDTH] : mul_product[WIDTH-1:0];
    mul_f.of = !op_mulh && (|mul_product[2*WIDTH-1:WIDTH]);
    mul_f.zf = (mul_r == '0);
    mul_f.nf = mul_r[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      flags_q   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      op_mulh   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_mul(aluc)) begin
              op_mulh <= (aluc == OP_MULH);
              state   <= MUL;
            end else begin
              r         <= alu_r;
              flags_q   <= alu_f;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            r         <= mul_r;
            flags_q   <= mul_f;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign zf = flags_q.zf;
  assign nf = flags_q.nf;
  assign cf = flags_q.cf;
  assign of = flags_q.of;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8 with hand-computed results and flags.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   aluc;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic         zf, nf, cf, of;
  logic [3:0]   flg;

  int checks = 0;
  int errors = 0;

  assign flg = {zf, nf, cf, of};

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .aluc     (aluc),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r        (r),
    .zf       (zf),
    .nf       (nf),
    .cf       (cf),
    .of       (of)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, scramble inputs after accept, check latency,
  // result and flags {zf,nf,cf,of}, then retire it with an out_ready pulse.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic ic, input int lat,
                        input logic [W-1:0] er, input logic [3:0] ef);
    check({tag, "_rdy0"}, 32'(in_ready), 1);
    aluc = op; a = ia; b = ib; cin = ic; in_valid = 1'b1;
    step();
    in_valid = 1'b0; a = ~ia; b = 8'h5A; cin = ~ic;
    for (int i = 0; i < lat; i++) begin
      if (out_valid !== 1'b0) check({tag, "_early"}, 32'(out_valid), 0);
      step();
    end
    check({tag, "_vld"}, 32'(out_valid), 1);
    check({tag, "_r"}, 32'(r), 32'(er));
    check({tag, "_flags"}, 32'(flg), 32'(ef));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle"}, 32'(in_ready), 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; aluc = '0; cin = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_r", 32'(r), 0);
    check("rst_flags", 32'(flg), 0);
    check("rst_vld", 32'(out_valid), 0);
    check("rst_rdy", 32'(in_ready), 1);

    run_op("add_ovf",  4'b0010, 8'h7F, 8'h01, 1'b0, 0, 8'h80, 4'b0101);
    run_op("add_cin",  4'b0010, 8'hFF, 8'h00, 1'b1, 0, 8'h00, 4'b1010);
    run_op("sub_brw",  4'b0110, 8'h00, 8'h01, 1'b0, 0, 8'hFF, 4'b0110);
    run_op("sub_zero", 4'b0110, 8'h05, 8'h05, 1'b0, 0, 8'h00, 4'b1000);
    run_op("sub_cin",  4'b0110, 8'h05, 8'h03, 1'b1, 0, 8'h01, 4'b0000);
    run_op("and",      4'b0000, 8'hAA, 8'h55, 1'b1, 0, 8'h00, 4'b1000);
    run_op("or",       4'b0001, 8'hAA, 8'h55, 1'b0, 0, 8'hFF, 4'b0100);
    run_op("nor",      4'b1100, 8'hA0, 8'h05, 1'b0, 0, 8'h5A, 4'b0000);
    run_op("nand",     4'b1101, 8'hF0, 8'h3C, 1'b0, 0, 8'hCF, 4'b0100);
    run_op("slt",      4'b0111, 8'h80, 8'h01, 1'b0, 0, 8'h01, 4'b0000);
    run_op("slt_no",   4'b0111, 8'h01, 8'h80, 1'b0, 0, 8'h00, 4'b1000);
    run_op("op_ill",   4'b0011, 8'hAA, 8'h55, 1'b1, 0, 8'h00, 4'b1000);
    run_op("mul",      4'b1110, 8'h10, 8'h10, 1'b0, W, 8'h00, 4'b1001);
    run_op("mulh",     4'b1111, 8'h10, 8'h10, 1'b0, W, 8'h01, 4'b0000);
    run_op("mul_ff",   4'b1110, 8'hFF, 8'hFF, 1'b0, W, 8'h01, 4'b0001);
    run_op("mulh_ff",  4'b1111, 8'hFF, 8'hFF, 1'b0, W, 8'hFE, 4'b0100);
    run_op("mul_small",4'b1110, 8'h0D, 8'h0B, 1'b0, W, 8'h8F, 4'b0100);

    // Backpressure: result held while a new request waits upstream.
    aluc = 4'b0010; a = 8'h01; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    step();
    a = 8'h10; b = 8'h20;
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", 32'(out_valid), 1);
      check("bp_r", 32'(r), 32'h02);
      check("bp_flags", 32'(flg), 0);
      check("bp_rdy", 32'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_idle_rdy", 32'(in_ready), 1);
    check("bp_idle_vld", 32'(out_valid), 0);
    step();
    in_valid = 1'b0;
    check("bp_new_vld", 32'(out_valid), 1);
    check("bp_new_r", 32'(r), 32'h30);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset three cycles into a multiply aborts it with no output.
    aluc = 4'b1110; a = 8'h0F; b = 8'h0F; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("abort_r", 32'(r), 0);
    check("abort_flags", 32'(flg), 0);
    check("abort_vld", 32'(out_valid), 0);
    step();
    rst = 1'b0;
    step();
    check("abort_rdy", 32'(in_ready), 1);
    for (int i = 0; i < W + 2; i++) begin
      if (out_valid !== 1'b0) check("abort_ghost", 32'(out_valid), 0);
      step();
    end
    run_op("add_after", 4'b0010, 8'h02, 8'h03, 1'b0, 0, 8'h05, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
